// File: rtl/sync_chan_burst_arbiter.sv
// sync_chan_burst_arbiter
//   Round-robin arbiter that lends one single-bit synchronizer channel to
//   NUM_REQ burst sources. A grant drives `len` cycles of 1 onto the
//   channel, then BURST_INDEX cycles of 0 so the downstream shift register
//   drains, then a one-cycle DONE pulse.
//   Optional feature: define SYNC_CHAN_ECHO_CHECK_EN to add the chan_echo
//   input and the sticky echo_err output, which compare the channel's
//   output against an internal reference shift register.
module sync_chan_burst_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_INDEX = 5,
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       chan_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id
`ifdef SYNC_CHAN_ECHO_CHECK_EN
  ,
  input  logic                       chan_echo,
  output logic                       echo_err
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = $clog2(BURST_INDEX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      id_q, id_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;

  logic [NUM_REQ-1:0] grant_q;
  logic               chan_out_q;
  logic               busy_q;
  logic               done_q;
  logic [IW-1:0]      done_id_q;

  logic [LEN_W-1:0]   lens_s [NUM_REQ];
  logic               win_found_s;
  logic [IW-1:0]      win_id_s;
  logic [LEN_W-1:0]   win_len_s;

  // Unpack the flat length bus into one field per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lens_s[i] = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Round-robin winner search starting at rr_q; scanning downward lets the
  // closest requester to rr_q overwrite the others. Length is clamped.
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_id_s    = {IW{1'b0}};
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (int'(rr_q) + k >= NUM_REQ) begin
        idx = int'(rr_q) + k - NUM_REQ;
      end else begin
        idx = int'(rr_q) + k;
      end
      if (req[IW'(idx)]) begin
        win_found_s = 1'b1;
        win_id_s    = IW'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
    if (lens_s[win_id_s] > LEN_W'(MAX_LEN)) begin
      win_len_s = LEN_W'(MAX_LEN);
    end else begin
      win_len_s = lens_s[win_id_s];
    end
  end

  // Next-state logic: burst and drain counters count down to 1 and then
  // hand over, so each phase lasts exactly its loaded count.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          id_d = win_id_s;
          if (win_len_s == {LEN_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BURST;
            bcnt_d  = win_len_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (bcnt_q <= LEN_W'(1)) begin
          state_d = S_DRAIN;
          bcnt_d  = {LEN_W{1'b0}};
          dcnt_d  = DW'(BURST_INDEX);
        end else begin
          bcnt_d  = bcnt_q - LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q <= DW'(1)) begin
          state_d = S_DONE;
          dcnt_d  = {DW{1'b0}};
        end else begin
          dcnt_d  = dcnt_q - DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (id_q == IW'(NUM_REQ - 1)) begin
          rr_d = {IW{1'b0}};
        end else begin
          rr_d = id_q + IW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state so
  // outputs line up with the cycle the FSM occupies.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      id_q       <= {IW{1'b0}};
      rr_q       <= {IW{1'b0}};
      bcnt_q     <= {LEN_W{1'b0}};
      dcnt_q     <= {DW{1'b0}};
      grant_q    <= {NUM_REQ{1'b0}};
      chan_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= {IW{1'b0}};
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      bcnt_q     <= bcnt_d;
      dcnt_q     <= dcnt_d;
      if (state_d == S_BURST || state_d == S_DRAIN) begin
        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_d;
      end else begin
        grant_q <= {NUM_REQ{1'b0}};
      end
      chan_out_q <= (state_d == S_BURST);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      done_id_q  <= (state_d == S_DONE) ? id_d : {IW{1'b0}};
    end
  end

  assign grant    = grant_q;
  assign chan_out = chan_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;

`ifdef SYNC_CHAN_ECHO_CHECK_EN
  logic [BURST_INDEX-1:0] ref_q;
  logic [BURST_INDEX-1:0] vld_q;
  logic                   echo_err_q;

  // Reference copy of the channel plus a valid pipe marking owned cycles;
  // a mismatch at the tap while valid sets the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q      <= {BURST_INDEX{1'b0}};
      vld_q      <= {BURST_INDEX{1'b0}};
      echo_err_q <= 1'b0;
    end else begin
      ref_q <= {ref_q[BURST_INDEX-2:0], chan_out_q};
      vld_q <= {vld_q[BURST_INDEX-2:0], (state_q == S_BURST || state_q == S_DRAIN)};
      if (vld_q[BURST_INDEX-1] && (chan_echo != ref_q[BURST_INDEX-1])) begin
        echo_err_q <= 1'b1;
      end else begin
        echo_err_q <= echo_err_q;
      end
    end
  end

  assign echo_err = echo_err_q;
`endif

endmodule

// File: tb/tb_sync_chan_burst_arbiter.sv
// Self-checking bench for sync_chan_burst_arbiter: a table of single-grant
// transactions feeds a scoreboard; a negedge monitor checks every grant.
module tb_sync_chan_burst_arbiter;

  localparam int NR = 4;
  localparam int BI = 5;
  localparam int LW = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic [NR-1:0]    grant;
  logic             chan_out;
  logic             busy;
  logic             done;
  logic [1:0]       done_id;
`ifdef SYNC_CHAN_ECHO_CHECK_EN
  logic             chan_echo;
  logic             echo_err;
  logic [BI-1:0]    chan_sr = '0;
  logic             force_echo = 1'b0;
  assign chan_echo = chan_sr[BI-1] | force_echo;
  always @(posedge clk) chan_sr <= {chan_sr[BI-2:0], chan_out};
`endif

  sync_chan_burst_arbiter #(.NUM_REQ(NR), .BURST_INDEX(BI), .MAX_LEN(16), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .grant(grant), .chan_out(chan_out), .busy(busy), .done(done), .done_id(done_id)
`ifdef SYNC_CHAN_ECHO_CHECK_EN
    , .chan_echo(chan_echo), .echo_err(echo_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [NR-1:0] req; int l0; int l1; int l2; int l3; int exp_id; int exp_len; } vec_t;
  typedef struct { int id; int len; } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*LW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
  endfunction

  // Monitor: per-transaction burst length, drain hygiene, one-hot grant, total length.
  initial begin
    int hi = 0;
    int cyc = 0;
    bit in_drain = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0; cyc = 0; in_drain = 1'b0;
      end else begin
        if (busy) cyc++;
        if (chan_out) begin
          chk("chan_in_drain", {31'd0, in_drain}, 32'd0);
          hi++;
        end else if (busy && hi > 0 && !done) begin
          in_drain = 1'b1;
        end
        if (busy && !done && (chan_out || in_drain) && exp_q.size() > 0)
          chk("grant_onehot", grant, 32'(4'b0001 << exp_q[0].id));
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_id", done_id, e.id);
            chk("burst_len", hi, e.len);
            chk("busy_cycles", cyc, (e.len == 0) ? 1 : e.len + BI + 1);
            chk("done_quiet", {grant, chan_out}, 32'd0);
          end
          hi = 0; cyc = 0; in_drain = 1'b0;
        end
      end
    end
  end

  // Drive one transaction from a negedge and wait (bounded) for its done.
  task automatic run_entry(input vec_t v);
    int n;
    req     = v.req;
    req_len = pack(v.l0, v.l1, v.l2, v.l3);
    exp_q.push_back('{v.exp_id, v.exp_len});
    if (done) @(negedge clk);
    @(negedge clk);
    if (v.exp_len > 0) begin
      chk("first_beat", chan_out, 32'd1);
      chk("first_grant", grant, 32'(4'b0001 << v.exp_id));
    end else begin
      chk("zero_len_done", done, 32'd1);
      chk("zero_len_quiet", {grant, chan_out}, 32'd0);
    end
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 32'd1);
  endtask

  vec_t tbl [13];
  vec_t v;

  initial begin
    int n;
    tbl[0]  = '{4'b1111, 2, 2, 2, 2, 0, 2};
    tbl[1]  = '{4'b1111, 2, 2, 2, 2, 1, 2};
    tbl[2]  = '{4'b1111, 2, 2, 2, 2, 2, 2};
    tbl[3]  = '{4'b1111, 2, 2, 2, 2, 3, 2};
    tbl[4]  = '{4'b1111, 2, 2, 2, 2, 0, 2};
    tbl[5]  = '{4'b0001, 3, 0, 0, 0, 0, 3};
    tbl[6]  = '{4'b0100, 0, 0, 0, 0, 2, 0};
    tbl[7]  = '{4'b0010, 0, 31, 0, 0, 1, 16};
    tbl[8]  = '{4'b1001, 1, 1, 1, 1, 3, 1};
    tbl[9]  = '{4'b1001, 1, 1, 1, 1, 0, 1};
    tbl[10] = '{4'b0110, 0, 16, 5, 0, 1, 16};
    tbl[11] = '{4'b1000, 0, 0, 0, 17, 3, 16};
    tbl[12] = '{4'b0001, 1, 0, 0, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {grant, chan_out, busy, done, done_id}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {grant, chan_out, busy, done, done_id}, 32'd0);

    for (int i = 0; i < 13; i++) run_entry(tbl[i]);
    req = '0;
    @(negedge clk);
    chk("idle_after_table", busy, 32'd0);

    // Reset on the 2nd burst cycle of an 8-beat grant to requester 2.
    req = 4'b0100; req_len = pack(0, 0, 8, 0);
    exp_q.push_back('{2, 8});
    @(negedge clk);
    chk("rst_seq_beat1", chan_out, 32'd1);
    @(negedge clk);
    chk("rst_seq_beat2", chan_out, 32'd1);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("rst_abort_outputs", {grant, chan_out, busy, done, done_id}, 32'd0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    v = '{4'b1111, 1, 1, 1, 1, 0, 1};
    run_entry(v);
    req = '0;
    @(negedge clk);

`ifdef SYNC_CHAN_ECHO_CHECK_EN
    chk("echo_clean", echo_err, 32'd0);
    req = 4'b0001; req_len = pack(2, 0, 0, 0);
    exp_q.push_back('{0, 2});
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !chan_out) && n < 20);
    chk("echo_drain_timeout", {31'd0, busy && !chan_out}, 32'd1);
    req = '0;
    force_echo = 1'b1;
    repeat (8) @(negedge clk);
    force_echo = 1'b0;
    chk("echo_err_set", echo_err, 32'd1);
    repeat (5) @(negedge clk);
    chk("echo_err_sticky", echo_err, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("echo_err_cleared", echo_err, 32'd0);
    exp_q.delete();
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
